// File: rtl/vga_scan_addr_gen.sv
// VGA timing plus frame-buffer read address with power-of-two upscale, BRAM-latency alignment
// and optional frame-synchronous scrolling (enabled by macro VGA_SCROLL_EN).
module vga_scan_addr_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SCALE_LOG2 = 1,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int ADDR_W     = 17,
    parameter int MEM_LAT    = 1,
    parameter int SYNC_POL   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic [1:0]        scroll_dir,
    input  logic [3:0]        scroll_step,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              valid,
    output logic [9:0]        h_cnt,
    output logic [9:0]        v_cnt,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);
    localparam int DEPTH   = 1 + MEM_LAT;

    localparam logic            SYNC_ACT = 1'(SYNC_POL);
    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG   = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG   = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0]     IMG_W_C  = 32'(IMG_W);
    localparam logic [31:0]     IMG_H_C  = 32'(IMG_H);

    logic [HC_W-1:0]   hc_r;
    logic [VC_W-1:0]   vc_r;
    logic              h_wrap_s;
    logic              frame_end_s;
    logic              hs_raw_s;
    logic              vs_raw_s;
    logic              act_raw_s;
    logic [31:0]       sx_s;
    logic [31:0]       sy_s;
    logic [31:0]       ix_s;
    logic [31:0]       iy_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DEPTH-1:0]  hs_pipe_r;
    logic [DEPTH-1:0]  vs_pipe_r;
    logic [DEPTH-1:0]  act_pipe_r;
    logic [9:0]        h_pipe_r [DEPTH];
    logic [9:0]        v_pipe_r [DEPTH];
    logic              fs_r;

`ifdef VGA_SCROLL_EN
    localparam int SX_W = $clog2(IMG_W + 1);
    localparam int SY_W = $clog2(IMG_H + 1);

    logic [SX_W-1:0] sx_r;
    logic [SY_W-1:0] sy_r;
    logic [31:0]     sx_nxt_s;
    logic [31:0]     sy_nxt_s;
    logic [31:0]     step_s;

    // Offsets widened for the address adders.
    always_comb begin
        sx_s = 32'(sx_r);
        sy_s = 32'(sy_r);
    end

    // Next scroll offsets, modulo by one conditional add/subtract.
    always_comb begin
        step_s   = 32'(scroll_step);
        sx_nxt_s = sx_s;
        sy_nxt_s = sy_s;
        case (scroll_dir)
            2'd0: begin
                sy_nxt_s = sy_s + step_s;
                if (sy_nxt_s >= IMG_H_C) sy_nxt_s = sy_nxt_s - IMG_H_C;
                else                     sy_nxt_s = sy_nxt_s;
            end
            2'd1: begin
                if (sy_s >= step_s) sy_nxt_s = sy_s - step_s;
                else                sy_nxt_s = sy_s + IMG_H_C - step_s;
            end
            2'd2: begin
                sx_nxt_s = sx_s + step_s;
                if (sx_nxt_s >= IMG_W_C) sx_nxt_s = sx_nxt_s - IMG_W_C;
                else                     sx_nxt_s = sx_nxt_s;
            end
            2'd3: begin
                if (sx_s >= step_s) sx_nxt_s = sx_s - step_s;
                else                sx_nxt_s = sx_s + IMG_W_C - step_s;
            end
            default: begin
                sx_nxt_s = sx_s;
                sy_nxt_s = sy_s;
            end
        endcase
    end

    // Offsets change only on the last pixel of a frame, never mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx_r <= {SX_W{1'b0}};
            sy_r <= {SY_W{1'b0}};
        end else if (pix_ce && frame_end_s) begin
            sx_r <= SX_W'(sx_nxt_s);
            sy_r <= SY_W'(sy_nxt_s);
        end
    end
`else
    logic unused_scroll_s;

    // Scroll disabled: fixed zero offsets, scroll inputs ignored.
    always_comb begin
        sx_s            = 32'd0;
        sy_s            = 32'd0;
        unused_scroll_s = ^{scroll_dir, scroll_step};
    end
`endif

    // Raw timing decode from the free-running counters.
    always_comb begin
        h_wrap_s    = (hc_r == H_LAST);
        frame_end_s = h_wrap_s && (vc_r == V_LAST);
        hs_raw_s    = ((hc_r >= HS_BEG) && (hc_r < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
        vs_raw_s    = ((vc_r >= VS_BEG) && (vc_r < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
        act_raw_s   = (hc_r < H_ACT_C) && (vc_r < V_ACT_C);
    end

    // Image coordinates wrap by one subtract, so the image tiles past its edge.
    always_comb begin
        ix_s = 32'(hc_r >> SCALE_LOG2) + sx_s;
        if (ix_s >= IMG_W_C) ix_s = ix_s - IMG_W_C;
        else                 ix_s = ix_s;
        iy_s = 32'(vc_r >> SCALE_LOG2) + sy_s;
        if (iy_s >= IMG_H_C) iy_s = iy_s - IMG_H_C;
        else                 iy_s = iy_s;
        if (act_raw_s) addr_s = ADDR_W'(iy_s * IMG_W_C + ix_s);
        else           addr_s = {ADDR_W{1'b0}};
    end

    // Raw horizontal/vertical counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_r <= {HC_W{1'b0}};
            vc_r <= {VC_W{1'b0}};
        end else if (pix_ce) begin
            if (h_wrap_s) begin
                hc_r <= {HC_W{1'b0}};
                if (vc_r == V_LAST) vc_r <= {VC_W{1'b0}};
                else                vc_r <= vc_r + VC_W'(1);
            end else begin
                hc_r <= hc_r + HC_W'(1);
            end
        end
    end

    // Address register and delay line matching the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= {ADDR_W{1'b0}};
            hs_pipe_r  <= {DEPTH{~SYNC_ACT}};
            vs_pipe_r  <= {DEPTH{~SYNC_ACT}};
            act_pipe_r <= {DEPTH{1'b0}};
            fs_r       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                h_pipe_r[i] <= 10'd0;
                v_pipe_r[i] <= 10'd0;
            end
        end else if (pix_ce) begin
            addr_r        <= addr_s;
            fs_r          <= frame_end_s;
            hs_pipe_r[0]  <= hs_raw_s;
            vs_pipe_r[0]  <= vs_raw_s;
            act_pipe_r[0] <= act_raw_s;
            h_pipe_r[0]   <= 10'(hc_r);
            v_pipe_r[0]   <= 10'(vc_r);
            for (int i = 1; i < DEPTH; i++) begin
                hs_pipe_r[i]  <= hs_pipe_r[i-1];
                vs_pipe_r[i]  <= vs_pipe_r[i-1];
                act_pipe_r[i] <= act_pipe_r[i-1];
                h_pipe_r[i]   <= h_pipe_r[i-1];
                v_pipe_r[i]   <= v_pipe_r[i-1];
            end
        end
    end

    assign pixel_addr  = addr_r;
    assign hsync       = hs_pipe_r[DEPTH-1];
    assign vsync       = vs_pipe_r[DEPTH-1];
    assign valid       = act_pipe_r[DEPTH-1];
    assign h_cnt       = h_pipe_r[DEPTH-1];
    assign v_cnt       = v_pipe_r[DEPTH-1];
    assign frame_start = fs_r;

endmodule

// File: tb/tb_vga_scan_addr_gen.sv
// Scoreboard bench for vga_scan_addr_gen on a shrunken raster (24x12 totals, 6x3 image, MEM_LAT=2).
module tb_vga_scan_addr_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int SL = 1, IW = 6, IH = 3, AW = 17, ML = 2, D = 1 + ML;

    typedef struct {
        int hs;
        int vs;
        int act;
        int h;
        int v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_ce = 1'b0;
    logic [1:0]    scroll_dir = 2'd0;
    logic [3:0]    scroll_step = 4'd0;
    logic [AW-1:0] pixel_addr;
    logic          hsync, vsync, valid, frame_start;
    logic [9:0]    h_cnt, v_cnt;

    int   checks_cnt = 0;
    int   errors_cnt = 0;
    exp_t exp_q[$];
    exp_t last_e;
    int   m_hc, m_vc, m_sx, m_sy, exp_addr, exp_fs;

    vga_scan_addr_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SCALE_LOG2(SL), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW),
        .MEM_LAT(ML), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .scroll_dir(scroll_dir), .scroll_step(scroll_step),
        .pixel_addr(pixel_addr), .hsync(hsync), .vsync(vsync), .valid(valid),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic exp_t raw_exp(input int hc, input int vc);
        exp_t e;
        e.hs  = (hc >= HA + HF && hc < HA + HF + HS) ? 0 : 1;
        e.vs  = (vc >= VA + VF && vc < VA + VF + VS) ? 0 : 1;
        e.act = (hc < HA && vc < VA) ? 1 : 0;
        e.h   = hc;
        e.v   = vc;
        return e;
    endfunction

    function automatic int addr_of(input int hc, input int vc, input int sx, input int sy);
        if (!(hc < HA && vc < VA)) return 0;
        return (((vc >> SL) + sy) % IH) * IW + (((hc >> SL) + sx) % IW);
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.hs = 1; e.vs = 1; e.act = 0; e.h = 0; e.v = 0;
        return e;
    endfunction

    // One clk: drive at negedge, advance the model, compare #1 after posedge.
    task automatic tick(input logic ce, input logic r);
        @(negedge clk);
        pix_ce = ce;
        rst    = r;
        if (r) begin
            m_hc = 0; m_vc = 0; m_sx = 0; m_sy = 0;
            exp_addr = 0; exp_fs = 0;
            exp_q.delete();
            for (int i = 0; i < D - 1; i++) exp_q.push_back(reset_exp());
            last_e = reset_exp();
        end else if (ce) begin
            exp_addr = addr_of(m_hc, m_vc, m_sx, m_sy);
            exp_fs   = (m_hc == HT - 1 && m_vc == VT - 1) ? 1 : 0;
            exp_q.push_back(raw_exp(m_hc, m_vc));
            last_e = exp_q.pop_front();
`ifdef VGA_SCROLL_EN
            if (exp_fs == 1) begin
                case (scroll_dir)
                    2'd0: m_sy = (m_sy + int'(scroll_step)) % IH;
                    2'd1: m_sy = (m_sy - int'(scroll_step) + IH) % IH;
                    2'd2: m_sx = (m_sx + int'(scroll_step)) % IW;
                    default: m_sx = (m_sx - int'(scroll_step) + IW) % IW;
                endcase
            end
`endif
            if (m_hc == HT - 1) begin
                m_hc = 0;
                m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
            end else begin
                m_hc = m_hc + 1;
            end
        end
        @(posedge clk);
        #1;
        check_val("pixel_addr", int'(pixel_addr), exp_addr);
        check_val("hsync", int'(hsync), last_e.hs);
        check_val("vsync", int'(vsync), last_e.vs);
        check_val("valid", int'(valid), last_e.act);
        check_val("h_cnt", int'(h_cnt), last_e.h);
        check_val("v_cnt", int'(v_cnt), last_e.v);
        check_val("frame_start", int'(frame_start), exp_fs);
    endtask

    initial begin
        int n;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        // Long run with irregular pix_ce and scroll inputs changing mid-frame.
        for (int i = 0; i < 2400; i++) begin
            if (i % 50 == 17) begin
                scroll_dir  = 2'($urandom_range(3, 0));
                scroll_step = 4'($urandom_range(3, 0));
            end
            tick(($urandom_range(2, 0) != 0) ? 1'b1 : 1'b0, 1'b0);
        end
        // Walk to raw (10,5), then reset with pix_ce high.
        n = 0;
        while (!(m_hc == 10 && m_vc == 5) && n < 2000) begin
            tick(1'b1, 1'b0);
            n++;
        end
        check_val("reach_raw_10_5", (m_hc == 10 && m_vc == 5) ? 1 : 0, 1);
        tick(1'b1, 1'b1);
        scroll_dir  = 2'd2;
        scroll_step = 4'd1;
        for (int i = 0; i < 900; i++) begin
            tick((i % 3 != 1) ? 1'b1 : 1'b0, 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
